dmem_responder: RTL and testbench

//   Data-memory responder serving the core's load/store path: accepts one request
//   (MemRead/MemWrite, byte address from ALUResult, store data from ReadData2, funct3),

---
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's load/store path.
// Accepts one request at a time (store when req_we=1, load otherwise) on a
// valid/ready request channel. It accesses an internal word RAM and returns
// RV32I-extended load data on a valid/ready response channel.
// Ports: clk, rst (synchronous, active high);
//   req_valid/req_ready/req_we/req_addr/req_funct3/req_wdata in;
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err out.
// Config macro: DMEM_MISALIGN_TRAP_EN. When defined, misaligned H/W accesses
// fault. When undefined, the address is forced to natural alignment.
module dmem_responder #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, state_nx;

    logic [31:0]   ram [DEPTH];
    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [2:0]    lat_f3;
    logic [31:0]   lat_wdata;
    logic [31:0]   word_q;
    logic          err_q;

    logic [31:0]   eff_addr;
    logic [AW-1:0] widx;
    logic          range_err;
    logic          f3_err;
    logic          mis;
    logic          acc_err;
    logic [3:0]    be;
    logic [31:0]   wdat;
    logic [31:0]   sh;
    logic [31:0]   ld_data;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = ACCESS;
            end
            ACCESS: state_nx = RESP;
            RESP: begin
                if (rsp_valid && rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Classification of the latched request.
    always_comb begin
        range_err = ({2'b00, lat_addr[31:2]} >= 32'(DEPTH));
        if (lat_we)
            f3_err = lat_f3[2] | (lat_f3[1:0] == 2'b11);
        else
            f3_err = (lat_f3[1:0] == 2'b11) | (lat_f3 == 3'b110);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = ((lat_f3[1:0] == 2'b01) & lat_addr[0])
            | ((lat_f3[1:0] == 2'b10) & (lat_addr[1:0] != 2'b00));
        eff_addr = lat_addr;
`else
        mis = 1'b0;
        eff_addr = lat_addr;
        if (lat_f3[1:0] == 2'b01) eff_addr[0]   = 1'b0;
        if (lat_f3[1:0] == 2'b10) eff_addr[1:0] = 2'b00;
`endif
        acc_err = range_err | f3_err | mis;
        widx    = eff_addr[AW+1:2];
    end

    // Store lanes: replicate the data so each lane sees its own byte.
    always_comb begin
        be   = 4'b0000;
        wdat = lat_wdata;
        case (lat_f3[1:0])
            2'b00: begin
                be   = 4'b0001 << eff_addr[1:0];
                wdat = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                be   = eff_addr[1] ? 4'b1100 : 4'b0011;
                wdat = {2{lat_wdata[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // RAM: no reset. A reset during ACCESS cancels the write.
    always_ff @(posedge clk) begin
        if (state == ACCESS) begin
            word_q <= ram[widx];
            if (!rst && lat_we && !acc_err) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ram[widx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    always_comb begin
        sh = word_q >> {eff_addr[1:0], 3'b000};
        case (lat_f3)
            3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
            3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
            3'b010:  ld_data = sh;
            3'b100:  ld_data = {24'd0, sh[7:0]};
            3'b101:  ld_data = {16'd0, sh[15:0]};
            default: ld_data = 32'd0;
        endcase
    end

    // The response register loads on the first RESP cycle. rsp_valid
    // therefore rises two edges after the request handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            err_q     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_f3    <= 3'd0;
            lat_wdata <= 32'd0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_f3    <= req_funct3;
                lat_wdata <= req_wdata;
            end
            if (state == ACCESS) err_q <= acc_err;
            if (state == RESP && !rsp_valid) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err_q;
                rsp_rdata <= (err_q || lat_we) ? 32'd0 : ld_data;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= 32'd0;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder.
// Expected responses are queued when a request is driven and compared on response.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .AW(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic we,
                       input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [31:0] er,
                       input logic ee, input int hold);
        int lat;
        logic [32:0] e;
        logic [31:0] d0;
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_funct3 = f3;
        req_wdata  = wd;
        rsp_ready  = (hold == 0);
        sb.push_back({ee, er});
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_addr   = 32'hFFFF_FFFF;
        req_funct3 = 3'b111;
        req_wdata  = 32'hA5A5_A5A5;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 8);
        chk({tag, "_latency"}, 32'(lat), 32'd2);
        if (sb.size() > 0) e = sb.pop_front();
        else e = 33'h1_FFFF_FFFF;
        chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
        chk({tag, "_err"}, 32'(rsp_err), 32'(e[32]));
        d0 = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, d0);
            chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_funct3 = 3'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;

        run("sw10", 1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0, 0);
        run("lw10", 0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0, 0);

        run("sb11", 1, 32'h11, 3'b000, 32'h0000_0080, 32'h0, 0, 0);
        run("lb11", 0, 32'h11, 3'b000, 32'h0, 32'hFFFFFF80, 0, 0);
        run("lbu11", 0, 32'h11, 3'b100, 32'h0, 32'h00000080, 0, 0);
        run("lw10b", 0, 32'h10, 3'b010, 32'h0, 32'hDEAD80EF, 0, 0);

        run("sh12", 1, 32'h12, 3'b001, 32'hFFFF_1234, 32'h0, 0, 0);
        run("lh12", 0, 32'h12, 3'b001, 32'h0, 32'h00001234, 0, 0);
        run("lw10c", 0, 32'h10, 3'b010, 32'h0, 32'h123480EF, 0, 0);
        run("lh10", 0, 32'h10, 3'b001, 32'h0, 32'hFFFF80EF, 0, 0);
        run("lhu10", 0, 32'h10, 3'b101, 32'h0, 32'h000080EF, 0, 0);
        run("lb13", 0, 32'h13, 3'b000, 32'h0, 32'h00000012, 0, 0);

`ifdef DMEM_MISALIGN_TRAP_EN
        run("lw13", 0, 32'h13, 3'b010, 32'h0, 32'h0, 1, 0);
        run("lh13", 0, 32'h13, 3'b001, 32'h0, 32'h0, 1, 0);
        run("sh11", 1, 32'h11, 3'b001, 32'hBBBB, 32'h0, 1, 0);
        run("lw10d", 0, 32'h10, 3'b010, 32'h0, 32'h123480EF, 0, 0);
`else
        run("lw13", 0, 32'h13, 3'b010, 32'h0, 32'h123480EF, 0, 0);
        run("lh13", 0, 32'h13, 3'b001, 32'h0, 32'h00001234, 0, 0);
        run("sh11", 1, 32'h11, 3'b001, 32'hBBBB, 32'h0, 0, 0);
        run("lw10d", 0, 32'h10, 3'b010, 32'h0, 32'h1234BBBB, 0, 0);
`endif

        run("sw0", 1, 32'h0, 3'b010, 32'h11111111, 32'h0, 0, 0);
        run("swtop", 1, 32'(4*DEPTH-4), 3'b010, 32'h01020304, 32'h0, 0, 0);
        run("lwtop", 0, 32'(4*DEPTH-4), 3'b010, 32'h0, 32'h01020304, 0, 0);
        run("swoor", 1, 32'(4*DEPTH), 3'b010, 32'h99999999, 32'h0, 1, 0);
        run("lw0", 0, 32'h0, 3'b010, 32'h0, 32'h11111111, 0, 0);
        run("lwoor", 0, 32'(4*DEPTH), 3'b010, 32'h0, 32'h0, 1, 0);
        run("ld011", 0, 32'h10, 3'b011, 32'h0, 32'h0, 1, 0);
        run("ld110", 0, 32'h10, 3'b110, 32'h0, 32'h0, 1, 0);
        run("st011", 1, 32'h0, 3'b011, 32'h22222222, 32'h0, 1, 0);
        run("st100", 1, 32'h0, 3'b100, 32'h33333333, 32'h0, 1, 0);
        run("lw0b", 0, 32'h0, 3'b010, 32'h0, 32'h11111111, 0, 0);

        run("sw20", 1, 32'h20, 3'b010, 32'hCAFEF00D, 32'h0, 0, 0);
        run("lwhold", 0, 32'h10, 3'b010, 32'h0, 32'h123480EF ^
`ifdef DMEM_MISALIGN_TRAP_EN
            32'h0,
`else
            32'h00003B54,
`endif
            0, 5);

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_funct3 = 3'b010;
        req_wdata  = 32'h00000055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_access_no_rsp", 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        run("lw20", 0, 32'h20, 3'b010, 32'h0, 32'hCAFEF00D, 0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
